edsac_tank_array: RTL and testbench

Parametrised bit-serial mercury-tank store: `N_TANKS` recirculating tanks of `WORDS` × `WORD_BITS` bits, shared by `N_CH` independent channels (arithmetic/order/input/output units).
- Each channel requests a whole-word read, write or clear by tank/word address and is serviced when that word passes the tank head.
- Generalises the fixed 32-tank, four-channel store with per-tank word addressing, per-channel handshake, arbitration and aligned monitor snapshots.
- Sits between the control/timing unit and the display/monitor logic.

---
 rtl/edsac_mem_pkg.sv | 23 ++
 rtl/edsac_tank.sv | 24 ++
 rtl/edsac_tank_array.sv | 167 ++++++++++++++++
 tb/tb_edsac_tank_array.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/edsac_mem_pkg.sv
// Shared encodings and default sizing for the mercury-tank store.
package edsac_mem_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_XFER,
    S_DONE
  } ch_state_e;

  localparam int DEF_N_TANKS   = 32;
  localparam int DEF_WORDS     = 16;
  localparam int DEF_WORD_BITS = 36;
  localparam int DEF_N_CH      = 4;

endpackage

// File: rtl/edsac_tank.sv
// One recirculating delay line: head at bit 0, tail refilled from head or from the owning channel.
module edsac_tank #(
  parameter int L = 576
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         own,
  input  logic         own_bit,
  output logic         head,
  output logic [L-1:0] nxt
);

  logic [L-1:0] q;

  assign head = q[0];
  assign nxt  = {(own ? own_bit : q[0]), q[L-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= nxt;
  end

endmodule

// File: rtl/edsac_tank_array.sv
// Multi-channel bit-serial tank store: timing counters, channel FSMs, word-start arbiter, monitor.
module edsac_tank_array
  import edsac_mem_pkg::*;
#(
  parameter int N_TANKS   = DEF_N_TANKS,
  parameter int WORDS     = DEF_WORDS,
  parameter int WORD_BITS = DEF_WORD_BITS,
  parameter int N_CH      = DEF_N_CH,
  parameter int TANK_AW   = $clog2(N_TANKS),
  parameter int WORD_AW   = $clog2(WORDS),
  localparam int BIT_AW   = $clog2(WORD_BITS),
  localparam int L        = WORDS * WORD_BITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_CH-1:0]         ch_req,
  input  logic [2*N_CH-1:0]       ch_op,
  input  logic [TANK_AW*N_CH-1:0] ch_tank,
  input  logic [WORD_AW*N_CH-1:0] ch_word,
  input  logic [N_CH-1:0]         ch_wbit,
  output logic [N_CH-1:0]         ch_rbit,
  output logic [N_CH-1:0]         ch_bit_stb,
  output logic [N_CH-1:0]         ch_busy,
  output logic [N_CH-1:0]         ch_ack,
  output logic [N_CH-1:0]         ch_err,
  output logic [BIT_AW-1:0]       bit_pos,
  output logic [WORD_AW-1:0]      word_pos,
  output logic [N_TANKS*L-1:0]    monitor,
  output logic                    monitor_stb
);

  localparam logic [BIT_AW-1:0]  BIT_LAST  = BIT_AW'(WORD_BITS - 1);
  localparam logic [WORD_AW-1:0] WORD_LAST = WORD_AW'(WORDS - 1);

  logic [N_CH-1:0][1:0]         op_v;
  logic [N_CH-1:0][TANK_AW-1:0] tank_v;
  logic [N_CH-1:0][WORD_AW-1:0] word_v;
  logic [N_CH-1:0]              waiting, xfer, grant;
  logic [N_TANKS-1:0]           own, own_bit, head;
  logic [N_TANKS-1:0][L-1:0]    nxt_v;
  logic                         word_start, frame_end;

  assign word_start = en && (bit_pos == '0);
  assign frame_end  = en && (bit_pos == BIT_LAST) && (word_pos == WORD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_pos  <= '0;
      word_pos <= '0;
    end else if (en) begin
      if (bit_pos == BIT_LAST) begin
        bit_pos  <= '0;
        word_pos <= (word_pos == WORD_LAST) ? '0 : word_pos + 1'b1;
      end else begin
        bit_pos  <= bit_pos + 1'b1;
      end
    end
  end

  // Readers share a word; a writer/clear needs it alone and lower indices take priority.
  always_comb begin
    grant = '0;
    for (int i = 0; i < N_CH; i++) begin
      grant[i] = word_start && waiting[i] && (word_v[i] == word_pos);
      for (int j = 0; j < i; j++)
        if (word_start && waiting[j] && (word_v[j] == word_pos) && (tank_v[j] == tank_v[i]) &&
            ((op_v[j] != OP_READ) || (op_v[i] != OP_READ)))
          grant[i] = 1'b0;
    end
  end

  always_comb begin
    own        = '0;
    own_bit    = '0;
    ch_bit_stb = '0;
    ch_rbit    = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch_bit_stb[i] = en && (xfer[i] || grant[i]);
      ch_rbit[i]    = ch_bit_stb[i] && head[tank_v[i]];
      if (ch_bit_stb[i] && (op_v[i] != OP_READ)) begin
        own[tank_v[i]]     = 1'b1;
        own_bit[tank_v[i]] = (op_v[i] == OP_WRITE) && ch_wbit[i];
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    ch_state_e          state_q, state_d;
    op_e                op_q;
    logic [TANK_AW-1:0] tank_q;
    logic [WORD_AW-1:0] word_q;
    logic               err_q, accept;
    logic [1:0]         req_op;
    logic [TANK_AW-1:0] req_tank;
    logic [WORD_AW-1:0] req_word;

    assign req_op   = ch_op[2*c +: 2];
    assign req_tank = ch_tank[TANK_AW*c +: TANK_AW];
    assign req_word = ch_word[WORD_AW*c +: WORD_AW];
    assign accept   = (state_q == S_IDLE) && ch_req[c] && (req_op != OP_NOP);

    // Bad addresses spend one cycle in WAIT so the error ack lands two cycles after the request.
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        S_IDLE:  if (accept) state_d = S_WAIT;
        S_WAIT:  if (err_q) state_d = S_DONE;
                 else if (grant[c]) state_d = S_XFER;
        S_XFER:  if (en && (bit_pos == BIT_LAST)) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= S_IDLE;
        op_q    <= OP_NOP;
        tank_q  <= '0;
        word_q  <= '0;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        if (accept) begin
          op_q   <= op_e'(req_op);
          tank_q <= req_tank;
          word_q <= req_word;
          err_q  <= (int'(req_tank) >= N_TANKS) || (int'(req_word) >= WORDS);
        end
      end
    end

    assign op_v[c]    = op_q;
    assign tank_v[c]  = tank_q;
    assign word_v[c]  = word_q;
    assign waiting[c] = (state_q == S_WAIT) && !err_q;
    assign xfer[c]    = (state_q == S_XFER);
    assign ch_busy[c] = (state_q != S_IDLE);
    assign ch_ack[c]  = (state_q == S_DONE);
    assign ch_err[c]  = (state_q == S_DONE) && err_q;
  end

  for (genvar t = 0; t < N_TANKS; t++) begin : g_tank
    edsac_tank #(.L(L)) u_tank (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .own     (own[t]),
      .own_bit (own_bit[t]),
      .head    (head[t]),
      .nxt     (nxt_v[t])
    );
  end

  // Post-shift contents at frame end are aligned: tank bit k holds word k/WORD_BITS, bit k%WORD_BITS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      monitor     <= '0;
      monitor_stb <= 1'b0;
    end else begin
      monitor_stb <= frame_end;
      if (frame_end) monitor <= nxt_v;
    end
  end

endmodule

// File: tb/tb_edsac_tank_array.sv
// Directed bench for edsac_tank_array with 3 tanks of 16 x 36-bit words and 4 channels.
module tb_edsac_tank_array;

  localparam int NT = 3, NW = 16, WB = 36, NC = 4, TAW = 2, WAW = 4, L = NW * WB;
  localparam logic [1:0] RD = 2'b01, WR = 2'b10, CLR = 2'b11;

  logic              clk = 1'b0, rst_n = 1'b0, en = 1'b1;
  logic [NC-1:0]     ch_req = '0;
  logic [2*NC-1:0]   ch_op = '0;
  logic [TAW*NC-1:0] ch_tank = '0;
  logic [WAW*NC-1:0] ch_word = '0;
  logic [NC-1:0]     ch_wbit;
  logic [NC-1:0]     ch_rbit, ch_bit_stb, ch_busy, ch_ack, ch_err;
  logic [5:0]        bit_pos;
  logic [3:0]        word_pos;
  logic [NT*L-1:0]   monitor;
  logic              monitor_stb;
  logic [WB-1:0]     wword [NC];
  int                checks = 0, failures = 0;

  always #5 clk = ~clk;

  // Write data follows the store's own bit counter so it is valid in the strobe cycle.
  always_comb for (int c = 0; c < NC; c++) ch_wbit[c] = wword[c][bit_pos];

  edsac_tank_array #(.N_TANKS(NT), .WORDS(NW), .WORD_BITS(WB), .N_CH(NC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ch_req(ch_req), .ch_op(ch_op), .ch_tank(ch_tank),
    .ch_word(ch_word), .ch_wbit(ch_wbit), .ch_rbit(ch_rbit), .ch_bit_stb(ch_bit_stb),
    .ch_busy(ch_busy), .ch_ack(ch_ack), .ch_err(ch_err), .bit_pos(bit_pos), .word_pos(word_pos),
    .monitor(monitor), .monitor_stb(monitor_stb)
  );

  task automatic set_req(input int c, input logic [1:0] op, input int t, input int w);
    ch_req[c]             = 1'b1;
    ch_op[2*c +: 2]       = op;
    ch_tank[TAW*c +: TAW] = TAW'(t);
    ch_word[WAW*c +: WAW] = WAW'(w);
  endtask

  task automatic do_xfer(input int c, input logic [1:0] op, input int t, input int w,
                         input logic [WB-1:0] wval, output logic [WB-1:0] data,
                         output int lat, output bit err, output bit ok);
    wword[c] = wval;
    @(negedge clk);
    set_req(c, op, t, w);
    @(negedge clk);
    ch_req = '0;
    data = '0; lat = 0; err = 0; ok = 0;
    for (int n = 1; n <= 1400; n++) begin
      if (ch_bit_stb[c]) data[bit_pos] = ch_rbit[c];
      if (ch_ack[c]) begin ok = 1; lat = n; err = ch_err[c]; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_mon(output bit ok);
    ok = 0;
    for (int n = 0; n < 700; n++) begin
      @(negedge clk);
      if (monitor_stb) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({ch_busy, ch_ack, ch_err, ch_bit_stb, ch_rbit} !== '0 || bit_pos !== 0 || word_pos !== 0 ||
        monitor !== '0 || monitor_stb !== 1'b0) begin
      failures++;
      $display("FAIL reset_state busy=%b ack=%b bit=%0d word=%0d stb=%b", ch_busy, ch_ack, bit_pos,
               word_pos, monitor_stb);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      checks++;
      if (monitor_stb !== (i % L == 0) || bit_pos !== 6'(i % WB) || word_pos !== 4'((i / WB) % NW)) begin
        failures++;
        $display("FAIL counters cyc=%0d got bit=%0d word=%0d mstb=%b exp bit=%0d word=%0d mstb=%b",
                 i, bit_pos, word_pos, monitor_stb, i % WB, (i / WB) % NW, i % L == 0);
      end
    end
    checks++;
    if (monitor !== '0) begin failures++; $display("FAIL monitor_zero got nonzero exp 0"); end
  endtask

  task automatic test_write_read;
    logic [WB-1:0] d; int lat; bit err, ok;
    do_xfer(0, WR, 2, 5, 36'hA5, d, lat, err, ok);
    checks++;
    if (!ok || err || lat > L + WB + 2) begin
      failures++; $display("FAIL write_ack ok=%b err=%b lat=%0d exp ok=1 err=0 lat<=%0d", ok, err, lat, L + WB + 2);
    end
    do_xfer(1, RD, 2, 5, '0, d, lat, err, ok);
    checks++;
    if (!ok || d !== 36'hA5) begin failures++; $display("FAIL read_a5 got=%h exp=%h ok=%b", d, 36'hA5, ok); end
    wait_mon(ok);
    checks++;
    if (!ok || monitor[1332 +: WB] !== 36'hA5) begin
      failures++; $display("FAIL monitor_a5 got=%h exp=%h ok=%b", monitor[1332 +: WB], 36'hA5, ok);
    end
  endtask

  task automatic test_arbitration;
    int t0, t2; logic [WB-1:0] d; int lat; bit err, ok;
    t0 = 0; t2 = 0;
    wword[0] = 36'h1; wword[2] = 36'h2;
    @(negedge clk);
    set_req(0, WR, 1, 0); set_req(2, WR, 1, 0);
    @(negedge clk);
    ch_req = '0;
    for (int n = 1; n <= 1500; n++) begin
      if (ch_ack[0]) t0 = n;
      if (ch_ack[2]) begin t2 = n; break; end
      @(negedge clk);
    end
    checks++;
    if (t0 == 0 || t2 == 0 || t2 - t0 != L) begin
      failures++; $display("FAIL arb_order ack0=%0d ack2=%0d exp ack2-ack0=%0d", t0, t2, L);
    end
    do_xfer(1, RD, 1, 0, '0, d, lat, err, ok);
    checks++;
    if (!ok || d !== 36'h2) begin failures++; $display("FAIL arb_final got=%h exp=%h", d, 36'h2); end
  endtask

  task automatic test_back_to_back;
    logic [WB-1:0] d1, d3; int mism; bit done, both;
    d1 = '0; d3 = '0; mism = 0; done = 0; both = 0;
    @(negedge clk);
    set_req(1, RD, 2, 5); set_req(3, RD, 2, 5);
    @(negedge clk);
    ch_req = '0;
    for (int n = 1; n <= 1400; n++) begin
      if (ch_bit_stb[1] !== ch_bit_stb[3]) mism++;
      if (ch_bit_stb[1]) d1[bit_pos] = ch_rbit[1];
      if (ch_bit_stb[3]) d3[bit_pos] = ch_rbit[3];
      if (ch_ack[1] || ch_ack[3]) begin done = 1; both = ch_ack[1] && ch_ack[3]; break; end
      @(negedge clk);
    end
    checks++;
    if (!done || !both || mism != 0) begin
      failures++; $display("FAIL shared_read done=%b both_ack=%b stb_diff=%0d exp 1 1 0", done, both, mism);
    end
    checks++;
    if (d1 !== 36'hA5 || d3 !== 36'hA5) begin
      failures++; $display("FAIL shared_data got=%h,%h exp=%h", d1, d3, 36'hA5);
    end
  endtask

  task automatic test_err_clear;
    logic [NT*L-1:0] snap; logic [WB-1:0] d; int lat; bit err, ok;
    wait_mon(ok);
    snap = monitor;
    @(negedge clk);
    set_req(0, RD, 3, 0);
    @(negedge clk);
    ch_req = '0;
    checks++;
    if (ch_busy[0] !== 1'b1 || ch_ack[0] !== 1'b0) begin
      failures++; $display("FAIL err_busy got busy=%b ack=%b exp 1 0", ch_busy[0], ch_ack[0]);
    end
    @(negedge clk);
    checks++;
    if (ch_ack[0] !== 1'b1 || ch_err[0] !== 1'b1) begin
      failures++; $display("FAIL err_ack got ack=%b err=%b exp 1 1", ch_ack[0], ch_err[0]);
    end
    @(negedge clk);
    checks++;
    if (ch_ack[0] !== 1'b0 || ch_busy[0] !== 1'b0) begin
      failures++; $display("FAIL err_idle got ack=%b busy=%b exp 0 0", ch_ack[0], ch_busy[0]);
    end
    wait_mon(ok);
    checks++;
    if (!ok || monitor !== snap) begin failures++; $display("FAIL err_no_change ok=%b monitor differs", ok); end
    do_xfer(2, CLR, 2, 5, '1, d, lat, err, ok);
    checks++;
    if (!ok || err) begin failures++; $display("FAIL clear_ack ok=%b err=%b exp 1 0", ok, err); end
    do_xfer(0, RD, 2, 5, '0, d, lat, err, ok);
    checks++;
    if (!ok || d !== '0) begin failures++; $display("FAIL clear_data got=%h exp=0", d); end
  endtask

  task automatic test_en_toggle;
    int s, a; bit seen_ack; logic [WB-1:0] d; int lat; bit err, ok;
    s = -1; a = -1; seen_ack = 0;
    wword[0] = 36'h9_1234_5678;
    @(negedge clk);
    set_req(0, WR, 0, 1);
    @(negedge clk);
    ch_req = '0;
    for (int n = 1; n <= 2600; n++) begin
      en = ~en;
      #1;
      if (ch_bit_stb[0] && s < 0) s = n;
      if (ch_ack[0]) begin a = n; break; end
      @(negedge clk);
    end
    en = 1'b1;
    checks++;
    if (s < 0 || a < 0 || a - s != 2 * (WB - 1) + 1) begin
      failures++; $display("FAIL en_toggle_lat got=%0d exp=%0d", a - s, 2 * (WB - 1) + 1);
    end
    do_xfer(1, RD, 0, 1, '0, d, lat, err, ok);
    checks++;
    if (!ok || d !== 36'h9_1234_5678) begin failures++; $display("FAIL en_toggle_data got=%h exp=%h", d, 36'h9_1234_5678); end
    // Abort a write part-way through its word.
    wword[0] = '1;
    @(negedge clk);
    set_req(0, WR, 0, 2);
    @(negedge clk);
    ch_req = '0;
    ok = 0;
    for (int n = 1; n <= 1400; n++) begin
      if (ch_busy[0] && ch_bit_stb[0] && bit_pos == 6'd10) begin ok = 1; break; end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || {ch_busy, ch_ack, ch_err, ch_bit_stb, ch_rbit} !== '0 || bit_pos !== 0 ||
        word_pos !== 0 || monitor !== '0 || monitor_stb !== 1'b0) begin
      failures++; $display("FAIL reset_abort reached=%b busy=%b ack=%b stb=%b bit=%0d", ok, ch_busy,
                           ch_ack, ch_bit_stb, bit_pos);
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (ch_ack !== '0) seen_ack = 1;
    end
    rst_n = 1'b1;
    wait_mon(ok);
    if (ch_ack !== '0) seen_ack = 1;
    checks++;
    if (!ok || seen_ack || monitor !== '0) begin
      failures++; $display("FAIL reset_tanks ok=%b ack_seen=%b monitor_zero=%b exp 1 0 1", ok, seen_ack, monitor == '0);
    end
  endtask

  initial begin
    for (int c = 0; c < NC; c++) wword[c] = '0;
    test_reset();
    test_write_read();
    test_arbitration();
    test_back_to_back();
    test_err_clear();
    test_en_toggle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
